// File: rtl/simd_alu.sv
// simd_alu: per-lane integer ALU for the SIMD execute stage.
// Provides a combinational result with neg/zero flags for same-cycle forwarding.
// It also provides a registered copy of the result and flags for writeback.
// Optional feature macro: ALU_CARRY_FLAG_EN adds a registered carry/borrow/overflow
// flag on output carryFlag.
module simd_alu #(
    parameter int dataSize = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          operation_select,
    input  logic [dataSize-1:0] operand1,
    input  logic [dataSize-1:0] operand2,
    output logic [dataSize-1:0] result,
    output logic                negFlag,
    output logic                zeroFlag,
    output logic [dataSize-1:0] result_q,
    output logic                negFlag_q,
    output logic                zeroFlag_q
`ifdef ALU_CARRY_FLAG_EN
    ,
    output logic                carryFlag
`endif
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_INC  = 3'b111;

    // Shift amounts at or beyond the lane width clear the result.
    localparam logic [dataSize:0] W_LIMIT = (dataSize + 1)'(dataSize);

    logic [dataSize-1:0] w_add;
    logic [dataSize-1:0] w_sub;
    logic [dataSize-1:0] w_mul_lo;
    logic [dataSize-1:0] w_inc;
    logic [dataSize-1:0] w_shl;
    logic [dataSize-1:0] w_shr;
    logic [dataSize-1:0] w_result;
    logic                w_shift_big;

    logic [dataSize-1:0] r_result;
    logic                r_neg;
    logic                r_zero;

    assign w_shift_big = ({1'b0, operand2} >= W_LIMIT);

`ifdef ALU_CARRY_FLAG_EN
    // The carry build keeps the full sum and product so the overflow parts are visible.
    logic                w_add_c;
    logic [dataSize-1:0] w_mul_hi;
    assign {w_add_c, w_add}     = {1'b0, operand1} + {1'b0, operand2};
    assign {w_mul_hi, w_mul_lo} = {{dataSize{1'b0}}, operand1} * {{dataSize{1'b0}}, operand2};
`else
    assign w_add    = operand1 + operand2;
    assign w_mul_lo = operand1 * operand2;
`endif

    assign w_sub = operand1 - operand2;
    assign w_inc = operand1 + {{(dataSize-1){1'b0}}, 1'b1};
    assign w_shl = w_shift_big ? {dataSize{1'b0}} : (operand1 << operand2);
    assign w_shr = w_shift_big ? {dataSize{1'b0}} : (operand1 >> operand2);

    // Opcode decode: select the lane result.
    always_comb begin
        w_result = {dataSize{1'b0}};
        case (operation_select)
            OP_PASS: w_result = operand1;
            OP_XOR:  w_result = operand1 ^ operand2;
            OP_ADD:  w_result = w_add;
            OP_SUB:  w_result = w_sub;
            OP_MUL:  w_result = w_mul_lo;
            OP_SHR:  w_result = w_shr;
            OP_SHL:  w_result = w_shl;
            OP_INC:  w_result = w_inc;
            default: w_result = {dataSize{1'b0}};
        endcase
    end

    assign result   = w_result;
    assign negFlag  = w_result[dataSize-1];
    assign zeroFlag = (w_result == {dataSize{1'b0}});

    // Writeback copy: reset clears, enable captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= {dataSize{1'b0}};
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (en) begin
            r_result <= w_result;
            r_neg    <= negFlag;
            r_zero   <= zeroFlag;
        end
    end

    assign result_q   = r_result;
    assign negFlag_q  = r_neg;
    assign zeroFlag_q = r_zero;

`ifdef ALU_CARRY_FLAG_EN
    logic w_carry;
    logic w_shl_lost;
    logic w_shr_lost;
    logic r_carry;

    // A shift loses a 1 exactly when reversing it does not restore the operand.
    assign w_shl_lost = w_shift_big ? (|operand1) : ((w_shl >> operand2) != operand1);
    assign w_shr_lost = w_shift_big ? (|operand1) : ((w_shr << operand2) != operand1);

    // Per-opcode carry/borrow/overflow indication.
    always_comb begin
        w_carry = 1'b0;
        case (operation_select)
            OP_ADD:  w_carry = w_add_c;
            OP_SUB:  w_carry = (operand1 < operand2);
            OP_INC:  w_carry = &operand1;
            OP_MUL:  w_carry = |w_mul_hi;
            OP_SHL:  w_carry = w_shl_lost;
            OP_SHR:  w_carry = w_shr_lost;
            default: w_carry = 1'b0;
        endcase
    end

    // Registered carry, same reset/enable behaviour as the other writeback flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (en) begin
            r_carry <= w_carry;
        end
    end

    assign carryFlag = r_carry;
`endif

endmodule

// File: tb/tb_simd_alu.sv
// Self-checking bench for simd_alu (dataSize = 8): directed vector table,
// reset/enable sequences, and random stimulus against an arithmetic model.
module tb_simd_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   operation_select;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [W-1:0] result;
    logic         negFlag;
    logic         zeroFlag;
    logic [W-1:0] result_q;
    logic         negFlag_q;
    logic         zeroFlag_q;
`ifdef ALU_CARRY_FLAG_EN
    logic         carryFlag;
`endif

    int errors = 0;
    int checks = 0;

    // Expected writeback state tracked by the bench.
    int exp_rq = 0;
    int exp_nq = 0;
    int exp_zq = 0;
    int exp_cq = 0;

    always #5 clk = ~clk;

    simd_alu #(.dataSize(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .operation_select (operation_select),
        .operand1         (operand1),
        .operand2         (operand2),
        .result           (result),
        .negFlag          (negFlag),
        .zeroFlag         (zeroFlag),
        .result_q         (result_q),
        .negFlag_q        (negFlag_q),
        .zeroFlag_q       (zeroFlag_q)
`ifdef ALU_CARRY_FLAG_EN
        ,
        .carryFlag        (carryFlag)
`endif
    );

    typedef struct {
        int op;
        int a;
        int b;
        int r;
        int c;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic modulo 256.
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int c);
        int p2;
        p2 = (b < W) ? (1 << b) : 0;
        r = 0;
        c = 0;
        case (op)
            0: begin r = a; end
            1: begin r = a ^ b; end
            2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            4: begin r = (a * b) % 256; c = (a * b > 255) ? 1 : 0; end
            5: begin
                if (b >= W) begin r = 0; c = (a != 0) ? 1 : 0; end
                else begin r = a / p2; c = ((a % p2) != 0) ? 1 : 0; end
            end
            6: begin
                if (b >= W) begin r = 0; c = (a != 0) ? 1 : 0; end
                else begin r = (a * p2) % 256; c = (a * p2 > 255) ? 1 : 0; end
            end
            default: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
        endcase
    endfunction

    // Drive one operation, check combinational outputs, clock it, check registers.
    task automatic apply(input string tag, input int op, input int a, input int b,
                         input logic r_in, input logic en_in, input int er, input int ec);
        @(negedge clk);
        rst              = r_in;
        en               = en_in;
        operation_select = op[2:0];
        operand1         = a[7:0];
        operand2         = b[7:0];
        #1;
        chk({tag, " result"},   int'(result),   er);
        chk({tag, " negFlag"},  int'(negFlag),  (er >= 128) ? 1 : 0);
        chk({tag, " zeroFlag"}, int'(zeroFlag), (er == 0) ? 1 : 0);
        @(posedge clk);
        if (r_in) begin
            exp_rq = 0; exp_nq = 0; exp_zq = 0; exp_cq = 0;
        end else if (en_in) begin
            exp_rq = er;
            exp_nq = (er >= 128) ? 1 : 0;
            exp_zq = (er == 0) ? 1 : 0;
            exp_cq = ec;
        end
        #1;
        chk({tag, " result_q"},   int'(result_q),   exp_rq);
        chk({tag, " negFlag_q"},  int'(negFlag_q),  exp_nq);
        chk({tag, " zeroFlag_q"}, int'(zeroFlag_q), exp_zq);
`ifdef ALU_CARRY_FLAG_EN
        chk({tag, " carryFlag"}, int'(carryFlag), exp_cq);
`endif
    endtask

    initial begin
        vec_t vecs[15];
        int   er;
        int   ec;
        int   op;
        int   a;
        int   b;
        logic r_in;
        logic en_in;

        rst = 1'b1; en = 1'b0; operation_select = 3'b000;
        operand1 = 8'h00; operand2 = 8'h00;

        //          op  a     b   result  carry
        vecs[0]  = '{2, 1,    3,  4,      0};
        vecs[1]  = '{3, 3,    2,  1,      0};
        vecs[2]  = '{4, 3,    2,  6,      0};
        vecs[3]  = '{5, 3,    1,  1,      1};
        vecs[4]  = '{6, 3,    2,  12,     0};
        vecs[5]  = '{1, 3,    2,  1,      0};
        vecs[6]  = '{3, 0,    0,  0,      0};
        vecs[7]  = '{3, 1,    3,  254,    1};
        vecs[8]  = '{7, 4,    0,  5,      0};
        vecs[9]  = '{7, 255,  0,  0,      1};
        vecs[10] = '{6, 1,    8,  0,      1};
        vecs[11] = '{2, 200,  100, 44,    1};
        vecs[12] = '{4, 16,   16, 0,      1};
        vecs[13] = '{0, 128,  5,  128,    0};
        vecs[14] = '{5, 128,  9,  0,      1};

        // Reset with enable high: registers clear, combinational path still live.
        apply("reset", 2, 1, 3, 1'b1, 1'b1, 4, 0);

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  1'b0, 1'b1, vecs[i].r, vecs[i].c);
        end

        // Reset priority, capture latency, and hold.
        apply("rst_pri",  2, 200, 100, 1'b1, 1'b1, 44, 1);
        apply("cap_add",  2, 1,   3,   1'b0, 1'b1, 4,  0);
        apply("hold",     1, 7,   85,  1'b0, 1'b0, 82, 0);
        apply("hold2",    7, 255, 0,   1'b0, 1'b0, 0,  1);
        apply("rst_noen", 0, 9,   0,   1'b1, 1'b0, 9,  0);

        // Randomised stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            op    = int'($urandom_range(0, 7));
            a     = int'($urandom_range(0, 255));
            b     = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 10))
                                                : int'($urandom_range(0, 255));
            r_in  = ($urandom_range(0, 19) == 0);
            en_in = ($urandom_range(0, 3) != 0);
            model(op, a, b, er, ec);
            apply("rand", op, a, b, r_in, en_in, er, ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
